uart_apb_tx_scheduler: RTL and testbench

- APB master that owns the CoreUARTapb slave port.
- Runs the UART configuration sequence after reset or on request: baud value, bit8/parity, fractional baud.
- Shares the UART transmitter between NUM_REQ byte-stream requesters using round-robin arbitration gated by TXRDY.
- Sits between the requester fabric and the UART wrapper, replacing direct CPU access to the UART registers.

---
 rtl/uart_apb_tx_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_apb_tx_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_tx_scheduler.sv
// APB master for the CoreUARTapb port: writes the UART configuration and round-robin shares TX
// between requesters. Optional RX drain of the UART receive register: define UART_APB_RX_DRAIN_EN.
module uart_apb_tx_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int REQ_IDW      = 2,
   parameter int HOLDOFF      = 2,
   parameter int CFG_ON_RESET = 1
) (
   input  logic                 PCLK,
   input  logic                 PRESETN,
   input  logic [12:0]          cfg_baud,
   input  logic [2:0]           cfg_frac,
   input  logic                 cfg_bit8,
   input  logic                 cfg_parity_en,
   input  logic                 cfg_odd_n_even,
   input  logic                 cfg_start,
   output logic                 cfg_done,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [REQ_IDW-1:0]   grant_id,
   output logic [4:0]           PADDR,
   output logic                 PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [7:0]           PWDATA,
   input  logic [7:0]           PRDATA,
   input  logic                 TXRDY,
   input  logic                 RXRDY,
   output logic                 rx_valid,
   output logic [7:0]           rx_data
);
   localparam logic [4:0] ADDR_TX    = 5'h00;
   localparam logic [4:0] ADDR_RX    = 5'h04;
   localparam logic [4:0] ADDR_CTRL1 = 5'h08;
   localparam logic [4:0] ADDR_CTRL2 = 5'h0C;
   localparam logic [4:0] ADDR_CTRL3 = 5'h14;
   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;
   localparam logic CFG_AUTO = (CFG_ON_RESET != 0);

   typedef enum logic [3:0] {
      IDLE, C1_S, C1_A, C2_S, C2_A, C3_S, C3_A, TX_S, TX_A, HOLD
`ifdef UART_APB_RX_DRAIN_EN
      , RX_S, RX_A
`endif
   } state_t;

   state_t state, state_nxt;

   logic              init_cap;
   logic              cfg_pend;
   logic [12:0]       baud_q;
   logic [2:0]        frac_q;
   logic              bit8_q;
   logic              par_q;
   logic              odd_q;
   logic [7:0]        tx_byte;
   logic [HOLD_W-1:0] hold_cnt;

   logic [REQ_IDW-1:0] rr_sel;
   logic [REQ_IDW-1:0] rr_cand;
   logic               rr_found;
   logic [7:0]         rr_byte;

   // Nearest valid requester after the last grant wins; scanning farthest-first lets the nearest overwrite.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = grant_id;
      rr_cand  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         rr_cand = REQ_IDW'((int'(grant_id) + k) % NUM_REQ);
         if (req_valid[rr_cand]) begin
            rr_found = 1'b1;
            rr_sel   = rr_cand;
         end
      end
      rr_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rr_sel == REQ_IDW'(i)) rr_byte = req_data[8*i +: 8];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cfg_pend) state_nxt = C1_S;
`ifdef UART_APB_RX_DRAIN_EN
            else if (cfg_done && RXRDY) state_nxt = RX_S;
`endif
            else if (cfg_done && TXRDY && rr_found) state_nxt = TX_S;
         end
         C1_S: state_nxt = C1_A;
         C1_A: state_nxt = C2_S;
         C2_S: state_nxt = C2_A;
         C2_A: state_nxt = C3_S;
         C3_S: state_nxt = C3_A;
         C3_A: state_nxt = IDLE;
         TX_S: state_nxt = TX_A;
         TX_A: state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
         HOLD: if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
`ifdef UART_APB_RX_DRAIN_EN
         RX_S: state_nxt = RX_A;
         RX_A: state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Bus outputs decode straight from the state so an asynchronous reset clears them at once.
   always_comb begin
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      PWRITE    = 1'b0;
      PADDR     = '0;
      PWDATA    = '0;
      req_ready = '0;
      case (state)
         C1_S, C1_A: begin
            PSEL    = 1'b1;
            PENABLE = (state == C1_A);
            PWRITE  = 1'b1;
            PADDR   = ADDR_CTRL1;
            PWDATA  = baud_q[7:0];
         end
         C2_S, C2_A: begin
            PSEL    = 1'b1;
            PENABLE = (state == C2_A);
            PWRITE  = 1'b1;
            PADDR   = ADDR_CTRL2;
            PWDATA  = {baud_q[12:8], odd_q, par_q, bit8_q};
         end
         C3_S, C3_A: begin
            PSEL    = 1'b1;
            PENABLE = (state == C3_A);
            PWRITE  = 1'b1;
            PADDR   = ADDR_CTRL3;
            PWDATA  = {5'b0, frac_q};
         end
         TX_S, TX_A: begin
            PSEL    = 1'b1;
            PENABLE = (state == TX_A);
            PWRITE  = 1'b1;
            PADDR   = ADDR_TX;
            PWDATA  = tx_byte;
         end
`ifdef UART_APB_RX_DRAIN_EN
         RX_S, RX_A: begin
            PSEL    = 1'b1;
            PENABLE = (state == RX_A);
            PADDR   = ADDR_RX;
         end
`endif
         default: ;
      endcase
      if (state == TX_A) req_ready = NUM_REQ'(1) << grant_id;
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state    <= IDLE;
         hold_cnt <= '0;
         grant_id <= '0;
         tx_byte  <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
         if (state == IDLE && state_nxt == TX_S) begin
            grant_id <= rr_sel;
            tx_byte  <= rr_byte;
         end
      end
   end

   // A request seen mid-sequence stays pending so the whole sequence reruns with the newest values.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         init_cap <= CFG_AUTO;
         cfg_pend <= CFG_AUTO;
         cfg_done <= 1'b0;
         baud_q   <= '0;
         frac_q   <= '0;
         bit8_q   <= 1'b0;
         par_q    <= 1'b0;
         odd_q    <= 1'b0;
      end else begin
         init_cap <= 1'b0;
         if (cfg_start || init_cap) begin
            baud_q <= cfg_baud;
            frac_q <= cfg_frac;
            bit8_q <= cfg_bit8;
            par_q  <= cfg_parity_en;
            odd_q  <= cfg_odd_n_even;
         end
         if (cfg_start) cfg_pend <= 1'b1;
         else if (state_nxt == C1_S) cfg_pend <= 1'b0;
         if (cfg_start) cfg_done <= 1'b0;
         else if (state == C3_A && !cfg_pend) cfg_done <= 1'b1;
      end
   end

`ifdef UART_APB_RX_DRAIN_EN
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= (state == RX_A);
         if (state == RX_A) rx_data <= PRDATA;
      end
   end
`else
   logic unused_rx;
   assign unused_rx = ^{PRDATA, RXRDY};
   assign rx_valid  = 1'b0;
   assign rx_data   = '0;
`endif

endmodule

// File: tb/tb_uart_apb_tx_scheduler.sv
// Directed bench for uart_apb_tx_scheduler: configuration, round-robin TX, cfg_start, reset and RX drain.
module tb_uart_apb_tx_scheduler;
   logic        PCLK;
   logic        PRESETN;
   logic [12:0] cfg_baud;
   logic [2:0]  cfg_frac;
   logic        cfg_bit8;
   logic        cfg_parity_en;
   logic        cfg_odd_n_even;
   logic        cfg_start;
   logic        cfg_done;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [1:0]  grant_id;
   logic [4:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PWDATA;
   logic [7:0]  PRDATA;
   logic        TXRDY;
   logic        RXRDY;
   logic        rx_valid;
   logic [7:0]  rx_data;

   int checks = 0;
   int errors = 0;
   logic [12:0] wr_q [$];

   uart_apb_tx_scheduler dut (
      .PCLK(PCLK), .PRESETN(PRESETN),
      .cfg_baud(cfg_baud), .cfg_frac(cfg_frac), .cfg_bit8(cfg_bit8),
      .cfg_parity_en(cfg_parity_en), .cfg_odd_n_even(cfg_odd_n_even),
      .cfg_start(cfg_start), .cfg_done(cfg_done),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .TXRDY(TXRDY), .RXRDY(RXRDY),
      .rx_valid(rx_valid), .rx_data(rx_data)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Log every completed APB write as {addr, data}.
   always @(negedge PCLK)
      if (PSEL && PENABLE && PWRITE) wr_q.push_back({PADDR, PWDATA});

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] valid, input logic [31:0] data, input logic txrdy);
      req_valid = valid;
      req_data  = data;
      TXRDY     = txrdy;
   endtask

   // mode 0: req_ready, 1: write SETUP, 2: cfg_done, 3: read SETUP
   task automatic wait_for(input int mode, input int limit, output int cycles);
      logic hit;
      cycles = 0;
      hit    = 1'b0;
      while (!hit && cycles < limit) begin
         @(negedge PCLK);
         cycles++;
         case (mode)
            0: hit = (req_ready != 4'b0);
            1: hit = PSEL && !PENABLE;
            2: hit = cfg_done;
            default: hit = PSEL && !PWRITE;
         endcase
      end
   endtask

   logic [4:0]  cfg_addr [6];
   logic [7:0]  cfg_wdat [6];
   logic [1:0]  exp_grant [4];
   logic [12:0] exp_wr [4];
   int cyc;
   int cnt;
   logic [12:0] obs_wr;

   initial begin
      cfg_addr  = '{5'h08, 5'h08, 5'h0C, 5'h0C, 5'h14, 5'h14};
      cfg_wdat  = '{8'h5C, 8'h5C, 8'h53, 8'h53, 8'h03, 8'h03};
      exp_grant = '{2'd2, 2'd0, 2'd2, 2'd0};

      PRESETN        = 1'b0;
      cfg_baud       = 13'h0A5C;
      cfg_frac       = 3'd3;
      cfg_bit8       = 1'b1;
      cfg_parity_en  = 1'b1;
      cfg_odd_n_even = 1'b0;
      cfg_start      = 1'b0;
      PRDATA         = 8'h00;
      RXRDY          = 1'b0;
      apply_stimulus(4'b0000, 32'h0, 1'b0);

      // Reset values
      repeat (3) @(negedge PCLK);
      check_output("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 32'h0);
      check_output("reset_misc", {req_ready, grant_id, cfg_done, rx_valid, rx_data}, 32'h0);

      // Configuration after reset release: six back-to-back cycles, cfg_done on the seventh
      PRESETN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge PCLK);
         check_output($sformatf("cfg_cycle%0d", i),
                      {cfg_done, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                      {1'b0, 1'b1, (i % 2 == 1), 1'b1, cfg_addr[i], cfg_wdat[i]});
      end
      @(negedge PCLK);
      check_output("cfg_done_rise", {cfg_done, PSEL}, 2'b10);

      // Requesters 0 and 2 compete; grants alternate starting after grant_id 0
      wr_q.delete();
      apply_stimulus(4'b0101, {8'h00, 8'h42, 8'h00, 8'h41}, 1'b1);
      for (int n = 0; n < 4; n++) begin
         wait_for(0, 40, cyc);
         if (n > 0) check_output($sformatf("tx_gap%0d", n), cyc, 5);
         check_output($sformatf("tx_ready%0d", n), req_ready, 4'b0001 << exp_grant[n]);
         check_output($sformatf("tx_grant%0d", n), grant_id, exp_grant[n]);
         check_output($sformatf("tx_bus%0d", n), {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                      {3'b111, 5'h00, (exp_grant[n] == 2'd2) ? 8'h42 : 8'h41});
         if (n == 3) req_valid = 4'b0000;
      end
      @(negedge PCLK);
      check_output("tx_write_count", wr_q.size(), 4);

      // TXRDY low blocks all grants; release grants (grant_id+1) mod 4
      apply_stimulus(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b0);
      cnt = 0;
      repeat (20) begin
         @(negedge PCLK);
         if (PSEL) cnt++;
      end
      check_output("txrdy_block_psel", cnt, 0);
      TXRDY = 1'b1;
      wait_for(0, 40, cyc);
      check_output("txrdy_release_ready", req_ready, 4'b0010);
      check_output("txrdy_release_data", PWDATA, 8'h11);
      req_valid = 4'b0000;
      repeat (4) @(negedge PCLK);

      // cfg_start during TX_S: transfer finishes, then the new configuration is written
      apply_stimulus(4'b1000, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b1);
      wait_for(1, 40, cyc);
      wr_q.delete();
      check_output("restart_grant", grant_id, 2'd3);
      cfg_baud       = 13'h0001;
      cfg_frac       = 3'd5;
      cfg_bit8       = 1'b0;
      cfg_parity_en  = 1'b0;
      cfg_odd_n_even = 1'b1;
      cfg_start      = 1'b1;
      @(negedge PCLK);
      cfg_start = 1'b0;
      check_output("restart_tx_access", {PSEL, PENABLE, PADDR, PWDATA, req_ready}, {2'b11, 5'h00, 8'h13, 4'b1000});
      check_output("restart_done_low", cfg_done, 1'b0);
      req_valid = 4'b0000;
      wait_for(2, 40, cyc);
      check_output("restart_done_high", cfg_done, 1'b1);
      exp_wr = '{{5'h00, 8'h13}, {5'h08, 8'h01}, {5'h0C, 8'h04}, {5'h14, 8'h05}};
      check_output("restart_write_count", wr_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         obs_wr = (i < wr_q.size()) ? wr_q[i] : 13'h1FFF;
         check_output($sformatf("restart_write%0d", i), obs_wr, exp_wr[i]);
      end

      // Asynchronous reset during TX_A, then reconfiguration and resend
      apply_stimulus(4'b0010, {8'h13, 8'h12, 8'h21, 8'h10}, 1'b1);
      wait_for(0, 40, cyc);
      check_output("rst_pre_grant", grant_id, 2'd1);
      #2 PRESETN = 1'b0;
      #1 check_output("rst_async_outputs",
                      {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, grant_id, cfg_done}, 32'h0);
      wr_q.delete();
      @(negedge PCLK);
      PRESETN = 1'b1;
      wait_for(0, 40, cyc);
      check_output("rst_resend_ready", req_ready, 4'b0010);
      req_valid = 4'b0000;
      @(negedge PCLK);
      exp_wr = '{{5'h08, 8'h01}, {5'h0C, 8'h04}, {5'h14, 8'h05}, {5'h00, 8'h21}};
      check_output("rst_write_count", wr_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         obs_wr = (i < wr_q.size()) ? wr_q[i] : 13'h1FFF;
         check_output($sformatf("rst_write%0d", i), obs_wr, exp_wr[i]);
      end
      repeat (4) @(negedge PCLK);

      // RX drain
      PRDATA = 8'h7E;
      RXRDY  = 1'b1;
`ifdef UART_APB_RX_DRAIN_EN
      wait_for(3, 40, cyc);
      check_output("rx_setup", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 5'h04});
      @(negedge PCLK);
      check_output("rx_access", {PSEL, PENABLE, PWRITE, PADDR}, {3'b110, 5'h04});
      @(negedge PCLK);
      check_output("rx_capture", {rx_valid, rx_data}, {1'b1, 8'h7E});
      RXRDY = 1'b0;
`endif
      cnt = 0;
      repeat (15) begin
         @(negedge PCLK);
         if ((PSEL && !PWRITE) || rx_valid) cnt++;
      end
      check_output("rx_no_extra_read", cnt, 0);
`ifndef UART_APB_RX_DRAIN_EN
      check_output("rx_tied_off", {rx_valid, rx_data}, 9'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
